mix_columns_fold: RTL

Parametrised, column-folded AES MixColumns engine for the shared round pipeline. It handles forward (encrypt) and inverse (decrypt) mode per block, plus a bypass for the final round. COLS_PER_CYCLE columns are processed per beat, which trades area against latency. A downstream stall holds the result, and overrun inputs are flagged.

---
 rtl/aes_pkg.sv | 70 +++++++
 rtl/mix_column_unit.sv | 22 ++
 rtl/mix_columns_fold.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, MixColumns coefficients, fold sizing
// and state indexing. The round stages use the same helpers.
package aes_pkg;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;
  localparam int STATE_W  = NUM_COLS * COL_W;

  // A column holds four bytes. Row 0 is the byte at the lowest state index.
  typedef logic [0:3][7:0] column_t;

  // Row 0 of each matrix. Row r is this row rotated right by r positions.
  localparam logic [0:3][7:0] FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fold_state_e;

  // Number of beats needed to cover all four columns.
  function automatic int beats_for(input int cols_per_cycle);
    return NUM_COLS / cols_per_cycle;
  endfunction

  // Column handled by a given lane during a given beat.
  function automatic logic [1:0] col_index(input int beat, input int lane,
                                           input int cols_per_cycle);
    return 2'(beat * cols_per_cycle + lane);
  endfunction

  // Byte b of a state, where byte 0 occupies the lowest bit indices.
  function automatic logic [7:0] state_byte(input logic [0:STATE_W-1] state,
                                            input int b);
    return state[8*b +: 8];
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using an xtime chain. All MixColumns
  // coefficients fit in four bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // One output byte of the column transform.
  function automatic logic [7:0] mix_byte(input column_t col, input logic [1:0] row,
                                          input logic inv);
    logic [7:0] acc;
    logic [1:0] k;
    logic [3:0] coef;
    acc = 8'h00;
    for (int j = 0; j < NUM_COLS; j++) begin
      k    = 2'(j) - row;
      coef = inv ? INV_COEF[k][3:0] : FWD_COEF[k][3:0];
      acc  = acc ^ gf_mul(col[j], coef);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational transform of one 32-bit column, forward or inverse.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [0:31] col_in,
  input  logic        mode,
  output logic [0:31] col_out
);

  column_t col;

  assign col = col_in;

  // Each output byte is the XOR of the four coefficient products for its row.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < NUM_COLS; r++) begin
      col_out[8*r +: 8] = mix_byte(col, 2'(r), mode);
    end
  end

endmodule

// File: rtl/mix_columns_fold.sv
// Column-folded AES MixColumns engine. It transforms COLS_PER_CYCLE columns
// per beat, holds the result under downstream stall and flags overrun strobes.
module mix_columns_fold
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [0:127]   in_data,
  input  logic           in_ready,
  input  logic           in_mode,
  input  logic           in_bypass,
  output logic           in_accept,
  output logic [0:127]   out_data,
  output logic           out_ready,
  input  logic           out_hold,
  output logic           in_drop,
  output logic           busy
);

  localparam int BEATS  = beats_for(COLS_PER_CYCLE);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_fold: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef logic [0:3][0:31] state_cols_t;

  fold_state_e state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  state_cols_t data_q, data_d;
  state_cols_t out_data_q, out_data_d;
  logic mode_q, mode_d;
  logic drop_q, drop_d;
  logic armed_q;
  logic take;
  logic last_beat;

  logic [1:0]  cidx    [COLS_PER_CYCLE];
  logic [0:31] col_sel [COLS_PER_CYCLE];
  logic [0:31] col_res [COLS_PER_CYCLE];

  // Lane j works on column beat*COLS_PER_CYCLE + j of the captured state.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign cidx[g]    = col_index(int'(beat_q), g, COLS_PER_CYCLE);
    assign col_sel[g] = data_q[cidx[g]];

    mix_column_unit u_col (
      .col_in  (col_sel[g]),
      .mode    (mode_q),
      .col_out (col_res[g])
    );
  end

  assign in_accept = (state_q == ST_IDLE) || ((state_q == ST_DONE) && !out_hold);
  assign out_ready = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign in_drop   = drop_q;

  // The first edge after reset release never captures a block.
  assign take      = in_ready && in_accept && armed_q;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Next-state, beat sequencing, capture and write-back of transformed columns.
  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    data_d     = data_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    drop_d     = in_ready && !in_accept;

    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          data_d = in_data;
          mode_d = in_mode;
          beat_d = '0;
          if (in_bypass) begin
            out_data_d = in_data;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          out_data_d[cidx[j]] = col_res[j];
        end
        if (last_beat) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!out_hold) begin
          if (take) begin
            data_d = in_data;
            mode_d = in_mode;
            beat_d = '0;
            if (in_bypass) begin
              out_data_d = in_data;
              state_d    = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers; reset discards any block in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      drop_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
      armed_q    <= 1'b1;
    end
  end

  // Captured input state register.
  // NOTE: left without reset on purpose; it is always written on capture before the FSM reads it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule
